scan_display_ctrl: RTL and testbench

- Scan controller for the 8-digit BCD/hex display.
- Holds the displayed frame and drives the digit-mux select (SEL) and the active-low anodes (AN) at a programmable refresh rate, with anti-ghosting dead time and optional leading-zero blanking.
- Accepts new frames through a valid/ready handshake and commits them only at a frame boundary, so the display never tears.
- Sits between the register/processor side and the digit mux plus segment decoder.

---
 rtl/scan_display_ctrl_if.sv | 21 ++
 rtl/scan_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_scan_display_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_display_ctrl_if.sv
// Frame-load handshake between the register side (master) and the scan controller (slave).
// LOAD_DATA holds eight ANCHO-bit digits, leftmost digit in the MSBs.
interface scan_display_ctrl_if #(
    parameter int ANCHO = 4
);
    logic                 LOAD_VALID;
    logic [8*ANCHO-1:0]   LOAD_DATA;
    logic                 LOAD_READY;

    modport master (
        output LOAD_VALID,
        output LOAD_DATA,
        input  LOAD_READY
    );

    modport slave (
        input  LOAD_VALID,
        input  LOAD_DATA,
        output LOAD_READY
    );
endinterface

// File: rtl/scan_display_ctrl.sv
// 8-digit multiplexed display scanner: frame buffering with tear-free commit,
// per-slot dead time, and optional leading-zero blanking.
module scan_display_ctrl #(
    parameter int ANCHO = 4,
    parameter int DIV   = 1000,
    parameter int DEAD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EN,
    input  logic                 LZB,
    scan_display_ctrl_if.slave   load,
    output logic [8*ANCHO-1:0]   FRAME,
    output logic [2:0]           SEL,
    output logic [7:0]           AN,
    output logic                 BLANK,
    output logic                 FRAME_DONE
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);

    generate
        if (DIV < 2) begin : g_bad_div
            $fatal(1, "scan_display_ctrl: DIV must be >= 2");
        end
        if ((DEAD < 0) || (DEAD >= DIV)) begin : g_bad_dead
            $fatal(1, "scan_display_ctrl: DEAD must satisfy 0 <= DEAD < DIV");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           sel_q, sel_d;
    logic                 frame_done_q, frame_done_d;
    logic [8*ANCHO-1:0]   frame_q, frame_d;
    logic [8*ANCHO-1:0]   pend_buf_q, pend_buf_d;
    logic                 pending_q, pending_d;
    logic                 lzb_q, lzb_d;

    logic                 slot_last;
    logic                 frame_wrap;
    logic                 commit;
    logic                 capture;
    logic [7:0]           digit_zero;
    logic [7:0]           lead_zero;
    logic                 blank;
    logic [7:0]           an;

    // digit_zero[k] refers to the digit shown when SEL=k (leftmost digit is k=0).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_zero[gi] = (frame_q[(7-gi)*ANCHO +: ANCHO] == '0);
            if (gi == 0) begin : g_first
                assign lead_zero[gi] = digit_zero[gi];
            end else begin : g_rest
                assign lead_zero[gi] = lead_zero[gi-1] & digit_zero[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
            frame_q      <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            lzb_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            frame_q      <= frame_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            lzb_q        <= lzb_d;
        end
    end

    always_comb begin
        state_d      = EN ? SCAN : IDLE;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        frame_d      = frame_q;
        pend_buf_d   = pend_buf_q;
        pending_d    = pending_q;
        lzb_d        = LZB;

        slot_last  = (state_q == SCAN) && (cnt_q == CNT_LAST);
        frame_wrap = slot_last && (sel_q == 3'd7);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sel_d = '0;
            end
            SCAN: begin
                if (!EN) begin
                    cnt_d = '0;
                    sel_d = '0;
                end else if (slot_last) begin
                    cnt_d        = '0;
                    sel_d        = sel_q + 3'd1;
                    frame_done_d = (sel_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                sel_d = '0;
            end
        endcase

        // Commit needs a full buffer and capture needs an empty one, so they never coincide.
        commit  = pending_q && ((state_q == IDLE) || frame_wrap);
        capture = load.LOAD_VALID && !pending_q;

        if (commit) begin
            frame_d   = pend_buf_q;
            pending_d = 1'b0;
        end else if (capture) begin
            pend_buf_d = load.LOAD_DATA;
            pending_d  = 1'b1;
        end
    end

    // Output decode depends only on registered state.
    always_comb begin
        blank = (state_q == SCAN) && lzb_q && (sel_q != 3'd7) && lead_zero[sel_q];
        an    = 8'hFF;
        if ((state_q == SCAN) && (cnt_q >= DEAD_C) && !blank) begin
            an = ~(8'h80 >> sel_q);
        end
    end

    assign FRAME           = frame_q;
    assign SEL             = sel_q;
    assign AN              = an;
    assign BLANK           = blank;
    assign FRAME_DONE      = frame_done_q;
    assign load.LOAD_READY = !pending_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl: a time-based display model predicts each cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_scan_display_ctrl;

    localparam int ANCHO = 4;
    localparam int DIV   = 4;
    localparam int DEAD  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EN;
    logic        LZB;
    logic [31:0] FRAME;
    logic [2:0]  SEL;
    logic [7:0]  AN;
    logic        BLANK;
    logic        FRAME_DONE;

    scan_display_ctrl_if #(.ANCHO(ANCHO)) lif();

    scan_display_ctrl #(
        .ANCHO (ANCHO),
        .DIV   (DIV),
        .DEAD  (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EN         (EN),
        .LZB        (LZB),
        .load       (lif),
        .FRAME      (FRAME),
        .SEL        (SEL),
        .AN         (AN),
        .BLANK      (BLANK),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] frame;
        logic [2:0]  sel;
        logic [7:0]  an;
        logic        blank;
        logic        done;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: m_t is the number of cycles since the scan started.
    bit          m_scan;
    int          m_t;
    logic [31:0] m_frame;
    logic [31:0] m_buf;
    bit          m_pend;
    bit          m_lzb;
    bit          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_scan  = 1'b0;
        m_t     = 0;
        m_frame = '0;
        m_pend  = 1'b0;
        m_lzb   = 1'b0;
        m_done  = 1'b0;
    endtask

    function automatic int m_sel();
        return m_scan ? (m_t / DIV) % 8 : 0;
    endfunction

    function automatic int m_phase();
        return m_scan ? m_t % DIV : 0;
    endfunction

    task automatic model_edge(input bit en, input bit lzb, input bit lv, input logic [31:0] ld);
        bit at_wrap;
        bit commit;
        at_wrap = m_scan && (m_phase() == DIV - 1) && (m_sel() == 7);
        commit  = m_pend && (!m_scan || at_wrap);
        m_done  = m_scan && en && at_wrap;
        if (commit) begin
            m_frame = m_buf;
            m_pend  = 1'b0;
        end else if (lv && !m_pend) begin
            m_buf  = ld;
            m_pend = 1'b1;
        end
        if (en) m_t = m_scan ? m_t + 1 : 0;
        else    m_t = 0;
        m_scan = en;
        m_lzb  = lzb;
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   s;
        s       = m_sel();
        e.sel   = 3'(s);
        e.frame = m_frame;
        e.blank = m_scan && m_lzb && (s != 7) && ((m_frame >> (4 * (7 - s))) == 32'd0);
        if (!m_scan || (m_phase() < DEAD) || e.blank) e.an = 8'hFF;
        else                                          e.an = ~(8'h01 << (7 - s));
        e.done  = m_done;
        e.ready = !m_pend;
        return e;
    endfunction

    task automatic step(input bit en, input bit lzb, input bit lv, input logic [31:0] ld);
        @(negedge clk);
        EN             = en;
        LZB            = lzb;
        lif.LOAD_VALID = lv;
        lif.LOAD_DATA  = ld;
        @(posedge clk);
        if (lv && !m_pend) $display("load %h accepted (t=%0t)", ld, $time);
        model_edge(en, lzb, lv, ld);
        exp_q.push_back(predict());
    endtask

    task automatic run_until(input int sel, input int phase, input bit en, input bit lzb);
        int n = 0;
        while (!(m_scan && m_sel() == sel && m_phase() == phase) && n < 100) begin
            step(en, lzb, 1'b0, 32'd0);
            n++;
        end
        chk("run_until_reached", 32'(m_scan && m_sel() == sel && m_phase() == phase), 32'd1);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_frame"}, FRAME, 32'd0);
        chk({name, "_sel"}, 32'(SEL), 32'd0);
        chk({name, "_an"}, 32'(AN), 32'hFF);
        chk({name, "_blank"}, 32'(BLANK), 32'd0);
        chk({name, "_done"}, 32'(FRAME_DONE), 32'd0);
        chk({name, "_ready"}, 32'(lif.LOAD_READY), 32'd1);
    endtask

    // Reset asserted between edges must take effect without a clock edge.
    task automatic do_reset_async();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset("rst_async");
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        EN             = 1'b0;
        LZB            = 1'b0;
        lif.LOAD_VALID = 1'b0;
        rst_n          = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame", FRAME, e.frame);
            chk("sel", 32'(SEL), 32'(e.sel));
            chk("an", 32'(AN), 32'(e.an));
            chk("blank", 32'(BLANK), 32'(e.blank));
            chk("frame_done", 32'(FRAME_DONE), 32'(e.done));
            chk("load_ready", 32'(lif.LOAD_READY), 32'(e.ready));
        end
    end

    initial begin : watchdog
        #1_000_000;
        checks++;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin : stim
        bit          cur_en;
        bit          cur_lzb;
        bit          lv;
        logic [31:0] ld;

        rst_n          = 1'b1;
        EN             = 1'b0;
        LZB            = 1'b0;
        lif.LOAD_VALID = 1'b0;
        lif.LOAD_DATA  = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #10;
        chk_reset("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Load while idle, then scan one full frame.
        step(1'b0, 1'b0, 1'b1, 32'h12345678);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (8 * DIV + 3) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Load mid-scan; a second offer while busy must be dropped.
        run_until(3, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hAAAA5555);
        repeat (3) step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        repeat (2 * 8 * DIV) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Leading-zero blanking, then an all-zero frame.
        step(1'b1, 1'b1, 1'b1, 32'h00000305);
        repeat (3 * 8 * DIV) step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h00000000);
        repeat (2 * 8 * DIV) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Disable mid-slot, load while idle, resume.
        run_until(5, 2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h90876501);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (8 * DIV + 2) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset mid-scan.
        run_until(5, 2, 1'b1, 1'b0);
        do_reset_async();

        // Randomised traffic.
        cur_en  = 1'b1;
        cur_lzb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) cur_en = !cur_en;
            if ($urandom_range(0, 99) == 0)  cur_lzb = !cur_lzb;
            lv = ($urandom_range(0, 9) == 0);
            ld = $urandom() >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 999) == 0) do_reset_async();
            step(cur_en, cur_lzb, lv, ld);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
